collision_detector: RTL and testbench

//  Produces the arrowHit strobe consumed by the bubble array, plus the player-death/lives path.
//  - Per-pixel overlap detection between arrow, player and bubble drawing requests, accumulated across one VGA frame.
//  - A detected hit is replayed as arrowHit, held high for the whole next frame.
//  - The bubble array then splits whichever bubble the scan covers while arrowHit=1.
//  - Sits between the object drawers and the game controller.

---
 rtl/collision_pkg.sv | 15 +
 rtl/frame_overlap_latch.sv | 25 ++
 rtl/collision_detector.sv | 165 ++++++++++++++++
 tb/tb_collision_detector.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared types and helpers for the collision detector.
// The optional hit statistics counter is enabled by the COLLISION_STATS_EN macro in collision_detector.
package collision_pkg;

   typedef enum logic [1:0] {ARMED, FIRE, HOLDOFF} arrow_st_t;
   typedef enum logic [1:0] {ALIVE, INVULN, DEAD} player_st_t;

   localparam int LIVES_W = 3;

   // Lives never wrap below zero.
   function automatic logic [LIVES_W-1:0] sat_dec(input logic [LIVES_W-1:0] v);
      return (v == '0) ? v : v - LIVES_W'(1);
   endfunction

endpackage

// File: rtl/frame_overlap_latch.sv
// Per-frame overlap flag: sets when both requests cover a pixel, restarts on startOfFrame.
// The consumer samples ov_o in the startOfFrame clk; an overlap in that clk seeds the new frame.
module frame_overlap_latch (
   input  logic clk,
   input  logic clr_i,
   input  logic sof_i,
   input  logic a_i,
   input  logic b_i,
   output logic ov_o
);

   logic ov_q;

   always_ff @(posedge clk) begin
      if (clr_i)
         ov_q <= 1'b0;
      else if (sof_i)
         ov_q <= a_i & b_i;
      else if (a_i & b_i)
         ov_q <= 1'b1;
   end

   assign ov_o = ov_q;

endmodule

// File: rtl/collision_detector.sv
// Arrow/player vs bubble collision detection with arrowHit replay, holdoff and lives handling.
// Define COLLISION_STATS_EN to add the saturating hitCount output.
module collision_detector
   import collision_pkg::*;
#(
   parameter int HIT_HOLDOFF_FRAMES = 4,
   parameter int INVULN_FRAMES      = 60,
   parameter int START_LIVES        = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               newGame,
   input  logic               arrowDrawingRequest,
   input  logic               bubbleDrawingRequest,
   input  logic               playerDrawingRequest,
   output logic               arrowHit,
   output logic               arrowRetract,
   output logic               playerHit,
   output logic [LIVES_W-1:0] lives,
   output logic               gameOver
`ifdef COLLISION_STATS_EN
   ,
   output logic [15:0]        hitCount
`endif
);

   localparam int HW = (HIT_HOLDOFF_FRAMES > 0) ? $clog2(HIT_HOLDOFF_FRAMES + 1) : 1;
   localparam int IW = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
   localparam logic [HW-1:0] HOLD_INIT = HW'((HIT_HOLDOFF_FRAMES > 0) ? HIT_HOLDOFF_FRAMES - 1 : 0);
   localparam logic [IW-1:0] INV_INIT  = IW'((INVULN_FRAMES > 0) ? INVULN_FRAMES - 1 : 0);

   logic clr;
   logic arrow_ov, player_ov;
   logic die_now, kill, fire_now;
   logic [LIVES_W-1:0] lives_d;

   arrow_st_t          ast_q;
   player_st_t         pst_q;
   logic [HW-1:0]      hcnt_q;
   logic [IW-1:0]      icnt_q;
   logic [LIVES_W-1:0] lives_q;
   logic               arrowHit_q, arrowRetract_q, playerHit_q, gameOver_q;

   assign clr = reset | newGame;

   frame_overlap_latch u_arrow_ov (
      .clk   (clk),
      .clr_i (clr),
      .sof_i (startOfFrame),
      .a_i   (arrowDrawingRequest),
      .b_i   (bubbleDrawingRequest),
      .ov_o  (arrow_ov)
   );

   frame_overlap_latch u_player_ov (
      .clk   (clk),
      .clr_i (clr),
      .sof_i (startOfFrame),
      .a_i   (playerDrawingRequest),
      .b_i   (bubbleDrawingRequest),
      .ov_o  (player_ov)
   );

   // Death in this frame boundary also suppresses an arrow hit accepted at the same boundary.
   always_comb begin
      lives_d  = sat_dec(lives_q);
      die_now  = startOfFrame && (pst_q == ALIVE) && player_ov && (lives_d == '0);
      kill     = (pst_q == DEAD) || die_now;
      fire_now = startOfFrame && (ast_q == ARMED) && arrow_ov && !kill;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         pst_q       <= ALIVE;
         icnt_q      <= '0;
         lives_q     <= LIVES_W'(START_LIVES);
         playerHit_q <= 1'b0;
         gameOver_q  <= 1'b0;
      end else begin
         playerHit_q <= 1'b0;
         if (startOfFrame) begin
            case (pst_q)
               ALIVE: if (player_ov) begin
                  lives_q     <= lives_d;
                  playerHit_q <= 1'b1;
                  if (lives_d == '0) begin
                     pst_q      <= DEAD;
                     gameOver_q <= 1'b1;
                  end else if (INVULN_FRAMES > 0) begin
                     pst_q  <= INVULN;
                     icnt_q <= INV_INIT;
                  end
               end
               INVULN: if ((icnt_q == '0) || (icnt_q == IW'(1))) begin
                  pst_q  <= ALIVE;
                  icnt_q <= '0;
               end else begin
                  icnt_q <= icnt_q - IW'(1);
               end
               default: pst_q <= pst_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr || kill) begin
         ast_q          <= ARMED;
         hcnt_q         <= '0;
         arrowHit_q     <= 1'b0;
         arrowRetract_q <= 1'b0;
      end else begin
         arrowRetract_q <= 1'b0;
         if (startOfFrame) begin
            case (ast_q)
               ARMED: if (fire_now) begin
                  ast_q          <= FIRE;
                  arrowHit_q     <= 1'b1;
                  arrowRetract_q <= 1'b1;
               end
               FIRE: begin
                  arrowHit_q <= 1'b0;
                  if (HIT_HOLDOFF_FRAMES > 0) begin
                     ast_q  <= HOLDOFF;
                     hcnt_q <= HOLD_INIT;
                  end else begin
                     ast_q <= ARMED;
                  end
               end
               HOLDOFF: if ((hcnt_q == '0) || (hcnt_q == HW'(1))) begin
                  ast_q  <= ARMED;
                  hcnt_q <= '0;
               end else begin
                  hcnt_q <= hcnt_q - HW'(1);
               end
               default: begin
                  ast_q      <= ARMED;
                  arrowHit_q <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef COLLISION_STATS_EN
   logic [15:0] hitCount_q;

   always_ff @(posedge clk) begin
      if (clr)
         hitCount_q <= '0;
      else if (fire_now && (hitCount_q != 16'hFFFF))
         hitCount_q <= hitCount_q + 16'd1;
   end

   assign hitCount = hitCount_q;
`endif

   assign arrowHit     = arrowHit_q;
   assign arrowRetract = arrowRetract_q;
   assign playerHit    = playerHit_q;
   assign lives        = lives_q;
   assign gameOver     = gameOver_q;

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector: frames are built from a startOfFrame clk plus a short body.
module tb_collision_detector;
   import collision_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic startOfFrame = 1'b0;
   logic newGame = 1'b0;
   logic arrowReq = 1'b0;
   logic bubbleReq = 1'b0;
   logic playerReq = 1'b0;
   logic arrowHit, arrowRetract, playerHit, gameOver;
   logic [2:0] lives;
`ifdef COLLISION_STATS_EN
   logic [15:0] hitCount;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   collision_detector #(
      .HIT_HOLDOFF_FRAMES (4),
      .INVULN_FRAMES      (60),
      .START_LIVES        (3)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .startOfFrame         (startOfFrame),
      .newGame              (newGame),
      .arrowDrawingRequest  (arrowReq),
      .bubbleDrawingRequest (bubbleReq),
      .playerDrawingRequest (playerReq),
      .arrowHit             (arrowHit),
      .arrowRetract         (arrowRetract),
      .playerHit            (playerHit),
      .lives                (lives),
      .gameOver             (gameOver)
`ifdef COLLISION_STATS_EN
      ,
      .hitCount             (hitCount)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic sof();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask

   task automatic body(input bit a, input bit p);
      for (int c = 0; c < 6; c++) begin
         if (c == 2) begin
            arrowReq  = a;
            playerReq = p;
            bubbleReq = a | p;
         end else begin
            arrowReq  = 1'b0;
            playerReq = 1'b0;
            bubbleReq = 1'b0;
         end
         tick();
      end
      arrowReq  = 1'b0;
      playerReq = 1'b0;
      bubbleReq = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({arrowHit, arrowRetract, playerHit, gameOver} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outs got %b want 0000", {arrowHit, arrowRetract, playerHit, gameOver});
      end
      checks++;
      if (lives !== 3'd3) begin
         errors++;
         $display("FAIL reset_lives got %0d want 3", lives);
      end
      body(1'b0, 1'b0);
      for (int f = 1; f <= 3; f++) begin
         sof();
         body(1'b0, 1'b0);
         checks++;
         if ({arrowHit, gameOver, lives} !== {1'b0, 1'b0, 3'd3}) begin
            errors++;
            $display("FAIL idle_frame%0d got hit=%b go=%b lives=%0d want 0 0 3", f, arrowHit, gameOver, lives);
         end
      end
   endtask

   task automatic test_arrow_single();
      do_reset();
      body(1'b1, 1'b0);
      sof();
      checks++;
      if ({arrowHit, arrowRetract} !== 2'b11) begin
         errors++;
         $display("FAIL single_sof1 got hit=%b retract=%b want 1 1", arrowHit, arrowRetract);
      end
      tick();
      checks++;
      if ({arrowHit, arrowRetract} !== 2'b10) begin
         errors++;
         $display("FAIL single_pulse got hit=%b retract=%b want 1 0", arrowHit, arrowRetract);
      end
      body(1'b0, 1'b0);
      checks++;
      if (arrowHit !== 1'b1) begin
         errors++;
         $display("FAIL single_hold got %b want 1", arrowHit);
      end
      sof();
      checks++;
      if (arrowHit !== 1'b0) begin
         errors++;
         $display("FAIL single_sof2 got %b want 0", arrowHit);
      end
      body(1'b0, 1'b0);
      checks++;
      if (arrowHit !== 1'b0) begin
         errors++;
         $display("FAIL single_after got %b want 0", arrowHit);
      end
   endtask

   task automatic test_holdoff();
      logic exp_hit;
      do_reset();
      for (int f = 0; f <= 7; f++) begin
         exp_hit = (f == 1) || (f == 6);
         if (f > 0) begin
            sof();
            checks++;
            if ({arrowHit, arrowRetract} !== {exp_hit, exp_hit}) begin
               errors++;
               $display("FAIL holdoff_sof%0d got hit=%b retract=%b want %b %b", f, arrowHit, arrowRetract, exp_hit, exp_hit);
            end
         end
         body(f <= 6, 1'b0);
         checks++;
         if (arrowHit !== exp_hit) begin
            errors++;
            $display("FAIL holdoff_frame%0d got %b want %b", f, arrowHit, exp_hit);
         end
      end
   endtask

   task automatic test_player();
      logic [2:0] exp_lives;
      logic       exp_ph;
      do_reset();
      exp_lives = 3'd3;
      for (int f = 0; f <= 141; f++) begin
         if (f > 0) begin
            sof();
            exp_ph = (f == 1) || (f == 71) || (f == 141);
            if (exp_ph) exp_lives = exp_lives - 3'd1;
            checks++;
            if ({playerHit, lives, gameOver} !== {exp_ph, exp_lives, (f >= 141)}) begin
               errors++;
               $display("FAIL player_sof%0d got ph=%b lives=%0d go=%b want %b %0d %b", f, playerHit, lives, gameOver, exp_ph, exp_lives, (f >= 141));
            end
         end
         body(1'b0, (f == 0) || (f == 1) || (f == 70) || (f == 140));
      end
      body(1'b1, 1'b1);
      sof();
      checks++;
      if ({arrowHit, arrowRetract, playerHit, lives, gameOver} !== {1'b0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
         errors++;
         $display("FAIL dead_sat got hit=%b ret=%b ph=%b lives=%0d go=%b want 0 0 0 0 1", arrowHit, arrowRetract, playerHit, lives, gameOver);
      end
   endtask

   task automatic test_sof_coincident();
      do_reset();
      body(1'b0, 1'b0);
      arrowReq     = 1'b1;
      bubbleReq    = 1'b1;
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      arrowReq     = 1'b0;
      bubbleReq    = 1'b0;
      checks++;
      if (arrowHit !== 1'b0) begin
         errors++;
         $display("FAIL coincident_sof1 got %b want 0", arrowHit);
      end
      body(1'b0, 1'b0);
      sof();
      checks++;
      if (arrowHit !== 1'b1) begin
         errors++;
         $display("FAIL coincident_sof2 got %b want 1", arrowHit);
      end
   endtask

   task automatic test_newgame();
      do_reset();
      for (int f = 0; f <= 61; f++) begin
         if (f > 0) sof();
         body(f == 61, (f == 0) || (f == 60));
      end
      checks++;
      if (lives !== 3'd1) begin
         errors++;
         $display("FAIL newgame_pre_lives got %0d want 1", lives);
      end
      sof();
      checks++;
      if (arrowHit !== 1'b1) begin
         errors++;
         $display("FAIL newgame_fire got %b want 1", arrowHit);
      end
`ifdef COLLISION_STATS_EN
      checks++;
      if (hitCount !== 16'd1) begin
         errors++;
         $display("FAIL newgame_pre_count got %0d want 1", hitCount);
      end
`endif
      tick();
      tick();
      newGame = 1'b1;
      tick();
      newGame = 1'b0;
      checks++;
      if ({arrowHit, lives, gameOver} !== {1'b0, 3'd3, 1'b0}) begin
         errors++;
         $display("FAIL newgame_outs got hit=%b lives=%0d go=%b want 0 3 0", arrowHit, lives, gameOver);
      end
      checks++;
      if ((dut.ast_q !== ARMED) || (dut.pst_q !== ALIVE)) begin
         errors++;
         $display("FAIL newgame_states got %0d %0d want ARMED ALIVE", dut.ast_q, dut.pst_q);
      end
`ifdef COLLISION_STATS_EN
      checks++;
      if (hitCount !== 16'd0) begin
         errors++;
         $display("FAIL newgame_count got %0d want 0", hitCount);
      end
`endif
      body(1'b1, 1'b1);
      sof();
      checks++;
      if ({arrowHit, playerHit, lives} !== {1'b1, 1'b1, 3'd2}) begin
         errors++;
         $display("FAIL newgame_rearm got hit=%b ph=%b lives=%0d want 1 1 2", arrowHit, playerHit, lives);
      end
   endtask

   initial begin
      test_reset();
      test_arrow_single();
      test_holdoff();
      test_player();
      test_sof_coincident();
      test_newgame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
